// File: rtl/bypass_unit.sv
// Operand bypass datapath: keeps a short history of retiring EX writes and forwards matching
// results to the ALU operands. Define BYPASS_STATS_EN to enable the forwarded-operand counter.
module bypass_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_SIZE = 5,
  parameter int unsigned DEPTH    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                p_enable,
  input  logic                b_enable,
  input  logic [REG_SIZE-1:0] r_b,
  input  logic [REG_SIZE-1:0] r_j,
  input  logic [REG_SIZE-1:0] r_k,
  input  logic [DATA_W-1:0]   rf_j_data,
  input  logic [DATA_W-1:0]   rf_k_data,
  input  logic                wr_valid,
  input  logic [REG_SIZE-1:0] wr_reg,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   op_j,
  output logic [DATA_W-1:0]   op_k,
  output logic                fwd_j,
  output logic                fwd_k,
  output logic                fwd_err,
  output logic [15:0]         fwd_count
);

  logic [DEPTH-1:0]    hist_valid_q;
  logic [REG_SIZE-1:0] hist_reg_q  [DEPTH];
  logic [DATA_W-1:0]   hist_data_q [DEPTH];

  logic                hit_j, hit_k, hit_b;
  logic [DATA_W-1:0]   hit_j_data, hit_k_data;
  logic                match_j, match_k, err_d;
  logic [DATA_W-1:0]   op_j_d, op_k_d;

  // Scan oldest to newest so the newest matching entry overrides older ones.
  always_comb begin
    hit_j      = 1'b0;
    hit_k      = 1'b0;
    hit_b      = 1'b0;
    hit_j_data = '0;
    hit_k_data = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (hist_valid_q[i] && hist_reg_q[i] == r_j) begin
        hit_j      = 1'b1;
        hit_j_data = hist_data_q[i];
      end
      if (hist_valid_q[i] && hist_reg_q[i] == r_k) begin
        hit_k      = 1'b1;
        hit_k_data = hist_data_q[i];
      end
      if (hist_valid_q[i] && hist_reg_q[i] == r_b) begin
        hit_b = 1'b1;
      end
    end
    match_j = b_enable && (r_j == r_b) && (r_j != '0) && hit_j;
    match_k = b_enable && (r_k == r_b) && (r_k != '0) && hit_k;
    err_d   = b_enable && (r_b != '0) && !hit_b;
    op_j_d  = match_j ? hit_j_data : rf_j_data;
    op_k_d  = match_k ? hit_k_data : rf_k_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        hist_reg_q[i]  <= '0;
        hist_data_q[i] <= '0;
      end
      op_j    <= '0;
      op_k    <= '0;
      fwd_j   <= 1'b0;
      fwd_k   <= 1'b0;
      fwd_err <= 1'b0;
    end else begin
      fwd_err <= 1'b0;
      if (p_enable) begin
        for (int i = int'(DEPTH) - 1; i > 0; i--) begin
          hist_valid_q[i] <= hist_valid_q[i-1];
          hist_reg_q[i]   <= hist_reg_q[i-1];
          hist_data_q[i]  <= hist_data_q[i-1];
        end
        // Writes to register 0 are recorded invalid so they can never match.
        hist_valid_q[0] <= wr_valid && (wr_reg != '0);
        hist_reg_q[0]   <= wr_reg;
        hist_data_q[0]  <= wr_data;
        op_j            <= op_j_d;
        op_k            <= op_k_d;
        fwd_j           <= match_j;
        fwd_k           <= match_k;
        fwd_err         <= err_d;
      end
    end
  end

`ifdef BYPASS_STATS_EN
  logic [15:0] count_q;
  logic [16:0] count_sum;

  always_comb begin
    count_sum = {1'b0, count_q} + {15'd0, match_j} + {15'd0, match_k};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (p_enable) begin
      count_q <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

  assign fwd_count = count_q;
`else
  assign fwd_count = 16'd0;
`endif

endmodule

// File: tb/tb_bypass_unit.sv
// Scoreboard bench for bypass_unit: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them one cycle after the sampling edge.
module tb_bypass_unit;

  logic        clk;
  logic        rst;
  logic        p_enable, b_enable;
  logic [4:0]  r_b, r_j, r_k;
  logic [31:0] rf_j_data, rf_k_data;
  logic        wr_valid;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] op_j, op_k;
  logic        fwd_j, fwd_k, fwd_err;
  logic [15:0] fwd_count;

  bypass_unit dut (
    .clk       (clk),
    .rst       (rst),
    .p_enable  (p_enable),
    .b_enable  (b_enable),
    .r_b       (r_b),
    .r_j       (r_j),
    .r_k       (r_k),
    .rf_j_data (rf_j_data),
    .rf_k_data (rf_k_data),
    .wr_valid  (wr_valid),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .op_j      (op_j),
    .op_k      (op_k),
    .fwd_j     (fwd_j),
    .fwd_k     (fwd_k),
    .fwd_err   (fwd_err),
    .fwd_count (fwd_count)
  );

  typedef struct {
    int          t;
    int          id;
    logic [31:0] oj, ok;
    logic        fj, fk, err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] h_oj = '0, h_ok = '0;
  logic        h_fj = 1'b0, h_fk = 1'b0;
  int          cnt_model = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].t <= cyc) begin
      if (sb[0].t < cyc) begin
        chk("stale_entry", sb[0].id, 32'(sb[0].t), 32'(cyc));
      end else begin
        chk("op_j", sb[0].id, op_j, sb[0].oj);
        chk("op_k", sb[0].id, op_k, sb[0].ok);
        chk("fwd_j", sb[0].id, {31'd0, fwd_j}, {31'd0, sb[0].fj});
        chk("fwd_k", sb[0].id, {31'd0, fwd_k}, {31'd0, sb[0].fk});
        chk("fwd_err", sb[0].id, {31'd0, fwd_err}, {31'd0, sb[0].err});
        chk("fwd_count", sb[0].id, {16'd0, fwd_count}, {16'd0, sb[0].cnt});
      end
      void'(sb.pop_front());
    end
  end

  task automatic push(input int id, input logic err);
    exp_t e;
    e.t   = cyc + 1;
    e.id  = id;
    e.oj  = h_oj;
    e.ok  = h_ok;
    e.fj  = h_fj;
    e.fk  = h_fk;
    e.err = err;
`ifdef BYPASS_STATS_EN
    e.cnt = 16'(cnt_model);
`else
    e.cnt = 16'd0;
`endif
    sb.push_back(e);
  endtask

  // Reset with bypass inputs active to show reset overrides them.
  task automatic do_reset(input int id);
    @(negedge clk);
    rst = 1'b1; p_enable = 1'b1; b_enable = 1'b1; r_b = 5'd3; r_j = 5'd3; r_k = 5'd3;
    rf_j_data = 32'h1; rf_k_data = 32'h2; wr_valid = 1'b1; wr_reg = 5'd3; wr_data = 32'h5;
    h_oj = '0; h_ok = '0; h_fj = 1'b0; h_fk = 1'b0; cnt_model = 0;
    push(id, 1'b0);
  endtask

  // Expected ops/flags only apply when pe=1; on a stall the previous values are held.
  task automatic step(input int id, input logic pe, input logic be, input logic [4:0] rb,
                      input logic [4:0] rj, input logic [4:0] rk, input logic [31:0] dj,
                      input logic [31:0] dk, input logic wv, input logic [4:0] wr,
                      input logic [31:0] wd, input logic [31:0] eoj, input logic [31:0] eok,
                      input logic efj, input logic efk, input logic eerr);
    @(negedge clk);
    rst = 1'b0; p_enable = pe; b_enable = be; r_b = rb; r_j = rj; r_k = rk;
    rf_j_data = dj; rf_k_data = dk; wr_valid = wv; wr_reg = wr; wr_data = wd;
    if (pe) begin
      h_oj = eoj; h_ok = eok; h_fj = efj; h_fk = efk;
      cnt_model = cnt_model + int'(efj) + int'(efk);
    end
    push(id, pe ? eerr : 1'b0);
  endtask

  initial begin
    rst = 1'b1; p_enable = 0; b_enable = 0; r_b = 0; r_j = 0; r_k = 0;
    rf_j_data = 0; rf_k_data = 0; wr_valid = 0; wr_reg = 0; wr_data = 0;
    do_reset(0);
    // id pe be rb rj rk dj dk wv wr wd | eoj eok fj fk err
    step(1, 1, 0, 0, 1, 2, 32'h11, 32'h22, 1, 3, 32'h1234, 32'h11, 32'h22, 0, 0, 0);
    step(2, 1, 1, 3, 3, 4, 32'hdead, 32'h55, 0, 0, 0, 32'h1234, 32'h55, 1, 0, 0);
    step(3, 1, 0, 0, 1, 2, 32'h1, 32'h2, 1, 5, 32'hA, 32'h1, 32'h2, 0, 0, 0);
    step(4, 1, 0, 0, 1, 2, 32'h3, 32'h4, 1, 5, 32'hB, 32'h3, 32'h4, 0, 0, 0);
    step(5, 1, 1, 5, 5, 5, 32'h99, 32'h98, 1, 6, 32'h66, 32'hB, 32'hB, 1, 1, 0);
    step(6, 0, 1, 5, 5, 2, 32'h1, 32'h2, 1, 8, 32'h88, 0, 0, 0, 0, 0);
    step(7, 0, 1, 9, 5, 2, 32'h1, 32'h2, 1, 8, 32'h89, 0, 0, 0, 0, 0);
    step(8, 1, 1, 6, 6, 5, 32'h1, 32'h77, 0, 0, 0, 32'h66, 32'h77, 1, 0, 0);
    step(9, 1, 1, 5, 5, 0, 32'h1, 32'h2, 0, 0, 0, 32'hB, 32'h2, 1, 0, 0);
    step(10, 1, 0, 0, 1, 2, 32'h5, 32'h6, 1, 0, 32'hFF, 32'h5, 32'h6, 0, 0, 0);
    step(11, 1, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(12, 1, 1, 9, 9, 2, 32'h900, 32'h200, 0, 0, 0, 32'h900, 32'h200, 0, 0, 1);
    step(13, 1, 0, 0, 1, 2, 32'h1, 32'h2, 0, 0, 0, 32'h1, 32'h2, 0, 0, 0);
    step(14, 1, 0, 0, 1, 2, 32'h3, 32'h4, 1, 7, 32'h77, 32'h3, 32'h4, 0, 0, 0);
    step(15, 1, 0, 0, 1, 2, 32'h5, 32'h6, 0, 0, 0, 32'h5, 32'h6, 0, 0, 0);
    step(16, 1, 0, 0, 1, 2, 32'h7, 32'h8, 0, 0, 0, 32'h7, 32'h8, 0, 0, 0);
    // r7 now sits in the oldest entry: last cycle it can be forwarded.
    step(17, 1, 1, 7, 7, 1, 32'h700, 32'h100, 0, 0, 0, 32'h77, 32'h100, 1, 0, 0);
    step(18, 1, 1, 7, 7, 1, 32'h700, 32'h100, 0, 0, 0, 32'h700, 32'h100, 0, 0, 1);
    step(19, 1, 0, 0, 1, 2, 32'ha, 32'hb, 1, 3, 32'h31, 32'ha, 32'hb, 0, 0, 0);
    step(20, 1, 1, 3, 3, 4, 32'h1, 32'hc, 1, 4, 32'h41, 32'h31, 32'hc, 1, 0, 0);
    do_reset(21);
    step(22, 1, 1, 3, 3, 4, 32'h3, 32'h4, 0, 0, 0, 32'h3, 32'h4, 0, 0, 1);
    step(23, 1, 0, 0, 1, 2, 32'h8, 32'h9, 0, 0, 0, 32'h8, 32'h9, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bypass_unit.md
Name: bypass_unit

Overview:
- Data-side partner of the hazard control unit. The control unit decides when a bypass is legal and which register to bypass (b_enable, r_b). This block holds the in-flight ALU results and supplies the forwarded operand values to the EX stage.
- Sits between the register file read port and the ALU operand inputs.
- Keeps a short history of retiring writes, advanced in lock-step with pipeline enable.

Parameters:
- DATA_W, 32, operand/result width
- REG_SIZE, 5, register index width
- DEPTH, 3, number of in-flight write history entries (EX, MEM, WB)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous active-high reset
- p_enable  input  1  pipeline advance (1 = shift history and load operands; 0 = stall)
- b_enable  input  1  bypass granted for this instruction
- r_b  input  REG_SIZE  register to bypass
- r_j  input  REG_SIZE  source register j of decoding instruction
- r_k  input  REG_SIZE  source register k of decoding instruction
- rf_j_data  input  DATA_W  register-file value for r_j
- rf_k_data  input  DATA_W  register-file value for r_k
- wr_valid  input  1  EX stage produces a register write this cycle
- wr_reg  input  REG_SIZE  EX destination register
- wr_data  input  DATA_W  EX result
- op_j  output  DATA_W  registered operand j to ALU
- op_k  output  DATA_W  registered operand k to ALU
- fwd_j  output  1  op_j came from history
- fwd_k  output  1  op_k came from history
- fwd_err  output  1  one-cycle pulse: b_enable asserted but no matching history entry
- fwd_count  output  16  forwarded-operand count (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): all history entries invalid; op_j, op_k = 0; fwd_j, fwd_k, fwd_err = 0; fwd_count = 0. Reset overrides p_enable and discards any in-progress bypass.
- History: DEPTH entries of {valid, reg, data}; entry 0 is newest.
- On posedge with p_enable=1:
  - entry[n] <= entry[n-1];
  - entry[0] <= {wr_valid && wr_reg!=0, wr_reg, wr_data}.
- On posedge with p_enable=0: history, op_j, op_k, fwd_j, fwd_k hold; fwd_err <= 0.
- Match for operand x (x = j or k): b_enable=1, r_x==r_b, r_x!=0, and some valid entry has reg==r_x.
  - Newest matching entry wins (entry 0 over 1 over 2).
  - Lookup uses the history before this edge's shift.
- Operand load (p_enable=1): op_x <= matched entry data if match, else rf_x_data; fwd_x <= match.
- r_j==r_k==r_b: both operands forwarded from the same entry.
- Register 0: never forwarded; op_x = rf_x_data and fwd_x = 0 even if b_enable=1 and r_b=0.
- fwd_err <= p_enable && b_enable && r_b!=0 && no valid entry with reg==r_b.
  - Operands then fall back to register-file data.
- b_enable=0: no forwarding regardless of history contents.
- Latency: operands valid 1 cycle after the sampling posedge.
- The control unit updates on negedge, so inputs are stable at posedge; no extra synchronisation.

Optional Feature:
- Macro BYPASS_STATS_EN.
- Defined: fwd_count increments by fwd_j+fwd_k (0, 1 or 2) on each posedge where operands are loaded; saturates at 16'hFFFF; cleared by rst.
- Undefined: counter logic absent; fwd_count tied to 0.

Test Plan:
- Reset: drive rst=1 one cycle mid-stream with history full -> op_j=op_k=0, fwd_j=fwd_k=0, fwd_count=0; a following b_enable=1, r_b=3 raises fwd_err=1.
- Simple forward: EX writes r3=0x1234 (p_enable=1); next cycle b_enable=1, r_b=3, r_j=3, r_k=4, rf_k_data=0x55 -> op_j=0x1234, fwd_j=1, op_k=0x55, fwd_k=0.
- Newest wins: consecutive EX writes r5=0xA then r5=0xB; then b_enable=1, r_b=5, r_j=r_k=5 -> op_j=op_k=0xB, fwd_j=fwd_k=1, fwd_count +2 with BYPASS_STATS_EN.
- Stall hold: after a forward, hold p_enable=0 for 2 cycles while wr_data changes -> op_j/op_k unchanged, history not shifted; resume p_enable=1 -> shift resumes.
- Register 0 and error: EX writes r0=0xFF; then b_enable=1, r_b=0, r_j=0, rf_j_data=0 -> op_j=0, fwd_j=0, fwd_err=0. Then b_enable=1, r_b=9 with no r9 in history -> fwd_err pulses 1 for one cycle, op_j=rf_j_data.
- Aging: write r7=0x77, then advance 3 cycles with wr_valid=0; b_enable=1, r_b=7 -> entry aged out, fwd_err=1, op_j=rf_j_data.
